// File: rtl/nmi_arb_pkg.sv
// Shared types and constants for the nmi round-robin arbiter.
package nmi_arb_pkg;

  // Read data returned upstream when the watchdog abandons a transaction.
  localparam logic [31:0] NMI_ARB_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } nmi_arb_state_e;

endpackage

// File: rtl/nmi_rr_pick.sv
// Combinational round-robin pick: first asserted valid after 'last', with wrap-around.
module nmi_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IdxW-1:0]    last,
  output logic               any,
  output logic [IdxW-1:0]    idx
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    any      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    // Offset NUM_REQ lands back on 'last', so it is considered with lowest priority.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand     = (32'(last) + k) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!any && valid[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/nmi_arbiter.sv
// Round-robin arbiter sharing one nmi bus among NUM_REQ requesters; req_*/nmi_* flatten the
// nmi_if slave/master bundles. Optional watchdog is enabled by defining NMI_ARB_TIMEOUT_EN.
module nmi_arbiter
  import nmi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned IdxW           = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  // Upstream requesters
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  input  logic [NUM_REQ-1:0][3:0]  req_wstrb,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0][31:0] req_rdata,
  // Downstream bus
  output logic                     nmi_valid,
  output logic [31:0]              nmi_addr,
  output logic [31:0]              nmi_wdata,
  output logic [3:0]               nmi_wstrb,
  input  logic                     nmi_ready,
  input  logic [31:0]              nmi_rdata,
  // Status
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     timeout_o
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : gen_bad_num_req
    $error("nmi_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("nmi_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  nmi_arb_state_e     state_q;
  logic [IdxW-1:0]    grant_q;
  logic [IdxW-1:0]    last_q;
  logic               pick_any;
  logic [IdxW-1:0]    pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               busy;
  logic               abort;
  logic               done;

  nmi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_pick (
    .valid (req_valid),
    .last  (last_q),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  assign busy = (state_q == StBusy);

`ifdef NMI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q;

  // Held at zero while idle so every grant starts counting from 0.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else if (!nmi_ready) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign abort = busy && !nmi_ready && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  assign done      = busy && (nmi_ready || abort);
  assign timeout_o = abort;

  assign nmi_valid = busy;
  assign nmi_addr  = req_addr[grant_q];
  assign nmi_wdata = req_wdata[grant_q];
  assign nmi_wstrb = req_wstrb[grant_q];

  always_comb begin
    req_ready = '0;
    req_rdata = '0;
    if (done) begin
      req_ready[grant_q] = 1'b1;
      req_rdata[grant_q] = abort ? NMI_ARB_ERR_RDATA : nmi_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      grant_o <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_any) begin
            state_q <= StBusy;
            grant_q <= pick_idx;
            grant_o <= pick_onehot;
          end
        end
        StBusy: begin
          if (done) begin
            state_q <= StIdle;
            last_q  <= grant_q;
            grant_o <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Directed bench for nmi_arbiter: inputs driven and outputs sampled on the falling clock edge.
module tb_nmi_arbiter;

  localparam int unsigned NumReq = 4;

  logic                    clk;
  logic                    rst_n;
  logic [NumReq-1:0]       req_valid;
  logic [NumReq-1:0][31:0] req_addr;
  logic [NumReq-1:0][31:0] req_wdata;
  logic [NumReq-1:0][3:0]  req_wstrb;
  logic [NumReq-1:0]       req_ready;
  logic [NumReq-1:0][31:0] req_rdata;
  logic                    nmi_valid;
  logic [31:0]             nmi_addr;
  logic [31:0]             nmi_wdata;
  logic [3:0]              nmi_wstrb;
  logic                    nmi_ready;
  logic [31:0]             nmi_rdata;
  logic [NumReq-1:0]       grant;
  logic                    timeout;

  int errors = 0;
  int checks = 0;

  nmi_arbiter #(
    .NUM_REQ        (NumReq),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_ready (req_ready),
    .req_rdata (req_rdata),
    .nmi_valid (nmi_valid),
    .nmi_addr  (nmi_addr),
    .nmi_wdata (nmi_wdata),
    .nmi_wstrb (nmi_wstrb),
    .nmi_ready (nmi_ready),
    .nmi_rdata (nmi_rdata),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, want finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    nmi_ready = 1'b0;
    nmi_rdata = '0;
    step();
    step();
    checks++;
    if (nmi_valid !== 1'b0) begin errors++; $display("FAIL reset_nmi_valid: got %b want 0", nmi_valid); end
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h1000_0000;
    #1;
    checks++;
    if (nmi_valid !== 1'b0) begin errors++; $display("FAIL single_T_idle: got %b want 0", nmi_valid); end
    step();
    checks++;
    if (nmi_valid !== 1'b1) begin errors++; $display("FAIL single_T1_valid: got %b want 1", nmi_valid); end
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", grant); end
    checks++;
    if (nmi_addr !== 32'h1000_0000) begin errors++; $display("FAIL single_addr: got %h want 10000000", nmi_addr); end
    for (int c = 2; c <= 3; c++) begin
      step();
      checks++;
      if (nmi_valid !== 1'b1 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL single_wait_T%0d: got valid=%b ready=%b want 1/0000", c, nmi_valid, req_ready);
      end
    end
    step();
    nmi_ready = 1'b1;
    nmi_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_T4_ready: got %b want 0010", req_ready); end
    checks++;
    if (req_rdata[1] !== 32'h1234_5678) begin errors++; $display("FAIL single_T4_rdata: got %h want 12345678", req_rdata[1]); end
    checks++;
    if (req_rdata[0] !== 32'h0) begin errors++; $display("FAIL single_other_rdata: got %h want 0", req_rdata[0]); end
    step();
    req_valid = '0;
    nmi_ready = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || nmi_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got grant=%b valid=%b want 0000/0", grant, nmi_valid);
    end
    step();
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    nmi_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      nmi_rdata = 32'h100 + i;
      #1;
      checks++;
      if (grant !== 4'(1 << i)) begin errors++; $display("FAIL simul_grant_%0d: got %b want %b", i, grant, 4'(1 << i)); end
      checks++;
      if (req_ready !== 4'(1 << i) || req_rdata[i] !== 32'h100 + i) begin
        errors++;
        $display("FAIL simul_ready_%0d: got ready=%b rdata=%h want %b/%h", i, req_ready, req_rdata[i],
                 4'(1 << i), 32'h100 + i);
      end
      req_valid[i] = 1'b0;
      step();
      checks++;
      if (grant !== 4'b0000 || nmi_valid !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL simul_idle_%0d: got grant=%b valid=%b ready=%b want 0000/0/0000", i, grant,
                 nmi_valid, req_ready);
      end
      step();
    end
    nmi_ready = 1'b0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp [4];
    exp[0] = 4'b0001;
    exp[1] = 4'b0100;
    exp[2] = 4'b0001;
    exp[3] = 4'b0001;
    req_valid = 4'b0101;
    nmi_ready = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (grant !== exp[k] || req_ready !== exp[k]) begin
        errors++;
        $display("FAIL fair_order_%0d: got grant=%b ready=%b want %b", k, grant, req_ready, exp[k]);
      end
      if (k == 1) req_valid[2] = 1'b0;
      step();
      checks++;
      if (grant !== 4'b0000) begin errors++; $display("FAIL fair_idle_%0d: got %b want 0000", k, grant); end
      if (k == 3) req_valid = '0;
      step();
    end
    nmi_ready = 1'b0;
  endtask

  task automatic test_write_steering();
    req_addr[0]  = 32'hFFFF_0000;
    req_wdata[0] = 32'h1111_2222;
    req_wstrb[0] = 4'b1111;
    req_addr[3]  = 32'h2000_0040;
    req_wdata[3] = 32'hA5A5_5A5A;
    req_wstrb[3] = 4'b0101;
    req_valid    = 4'b1000;
    step();
    checks++;
    if (grant !== 4'b1000 || nmi_valid !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant: got grant=%b valid=%b want 1000/1", grant, nmi_valid);
    end
    checks++;
    if (nmi_addr !== 32'h2000_0040 || nmi_wdata !== 32'hA5A5_5A5A || nmi_wstrb !== 4'b0101) begin
      errors++;
      $display("FAIL wr_fields: got %h/%h/%b want 20000040/a5a55a5a/0101", nmi_addr, nmi_wdata, nmi_wstrb);
    end
    nmi_ready = 1'b1;
    nmi_rdata = 32'h0;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL wr_ready: got %b want 1000", req_ready); end
    step();
    req_valid = '0;
    nmi_ready = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    req_valid = 4'b0010;
    step();
`ifdef NMI_ARB_TIMEOUT_EN
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (timeout !== 1'b0 || req_ready !== 4'b0000 || nmi_valid !== 1'b1) begin
        errors++;
        $display("FAIL to_wait_%0d: got to=%b ready=%b valid=%b want 0/0000/1", c, timeout, req_ready, nmi_valid);
      end
      step();
    end
    checks++;
    if (timeout !== 1'b1 || req_ready !== 4'b0010 || req_rdata[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL to_abort: got to=%b ready=%b rdata=%h want 1/0010/deadbeef", timeout, req_ready, req_rdata[1]);
    end
    req_valid = '0;
    step();
    checks++;
    if (timeout !== 1'b0 || nmi_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_after: got to=%b valid=%b want 0/0", timeout, nmi_valid);
    end
    req_valid = 4'b0010;
    step();
    for (int c = 1; c <= 7; c++) step();
    nmi_ready = 1'b1;
    nmi_rdata = 32'h5555_AAAA;
    #1;
    checks++;
    if (timeout !== 1'b0 || req_ready !== 4'b0010 || req_rdata[1] !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL to_race: got to=%b ready=%b rdata=%h want 0/0010/5555aaaa", timeout, req_ready, req_rdata[1]);
    end
`else
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (timeout !== 1'b0 || req_ready !== 4'b0000 || nmi_valid !== 1'b1) begin
        errors++;
        $display("FAIL nto_hold_%0d: got to=%b ready=%b valid=%b want 0/0000/1", c, timeout, req_ready, nmi_valid);
      end
      step();
    end
    nmi_ready = 1'b1;
    nmi_rdata = 32'h5555_AAAA;
    #1;
    checks++;
    if (req_ready !== 4'b0010 || req_rdata[1] !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL nto_done: got ready=%b rdata=%h want 0010/5555aaaa", req_ready, req_rdata[1]);
    end
`endif
    step();
    req_valid = '0;
    nmi_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    req_valid = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL rmb_grant: got %b want 0100", grant); end
    rst_n = 1'b0;
    step();
    checks++;
    if (nmi_valid !== 1'b0 || grant !== 4'b0000 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rmb_abandon: got valid=%b grant=%b ready=%b want 0/0000/0000", nmi_valid, grant, req_ready);
    end
    rst_n     = 1'b1;
    req_valid = 4'b0101;
    step();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL rmb_first: got %b want 0001", grant); end
    nmi_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmb_ready: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    nmi_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_write_steering();
    test_timeout();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
